// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver with a valid/ready output handshake.
// The serial input is double-flopped. Each bit is sampled at its midpoint,
// found by timing half a bit into the start bit. Completed words are held
// on data_out until the consumer accepts them.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 8)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     stop bits checked (1 or 2)
//
// Ports
//   clk         single clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   rx          asynchronous serial line, idle high
//   data_out    received word, LSB = first data bit on the line
//   valid       data_out / parity_err / frame_err hold a word
//   ready       consumer accepts the held word (ignored while valid is low)
//   parity_err  parity mismatch for the held word
//   frame_err   a stop bit of the held word was sampled low
//   overrun     one-cycle pulse when a completed frame is dropped
//   busy        receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  // Required XOR of data and parity bit: 0 for even parity, 1 for odd.
  localparam logic             ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_sync;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bad, par_bad_n;
  logic                 frm_bad, frm_bad_n;
  logic                 done, done_n;
  logic                 bit_tick;

  // Synchroniser resets to the idle line level, so a reset is never
  // mistaken for a start bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_bad <= par_bad_n;
      frm_bad <= frm_bad_n;
      done    <= done_n;
    end
  end

  assign bit_tick = (cnt == LAST_CNT);

  // idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    par_bad_n = par_bad;
    frm_bad_n = frm_bad;
    done_n    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end

      // Recheck the line at mid start bit. A line that is high again was a
      // glitch, so the receiver returns to idle.
      ST_START: begin
        if (cnt == HALF_BIT) begin
          cnt_n     = '0;
          idx_n     = '0;
          par_bad_n = 1'b0;
          frm_bad_n = 1'b0;
          state_n   = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[DATA_BITS-1:1]};
          if (idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = (PARITY == 0) ? ST_STOP : ST_PARITY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          cnt_n     = '0;
          par_bad_n = ((^shift) ^ rx_sync) != ODD_PAR;
          state_n   = ST_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // A low final stop bit means the line is held low (break or
      // misframe). The receiver then waits in BREAK so that the low line
      // is not taken as a new start bit.
      ST_STOP: begin
        if (bit_tick) begin
          cnt_n = '0;
          if (!rx_sync) frm_bad_n = 1'b1;
          if (idx == STOP_LAST) begin
            idx_n   = '0;
            done_n  = 1'b1;
            state_n = rx_sync ? ST_IDLE : ST_BREAK;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_BREAK: begin
        if (rx_sync) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Output holding register. A word that completes during a handshake
  // replaces the accepted word. A word that completes while the held word
  // is still pending is dropped and flagged with overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data_out   <= shift;
          parity_err <= par_bad;
          frame_err  <= frm_bad;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param. Four instances share one clock:
//   u0  default parameters (868 clk/bit, 8N1)
//   u1  16 clk/bit, even parity
//   u2  16 clk/bit, 8N1 (break and overrun scenarios)
//   u3  16 clk/bit, 7 data bits, 2 stop bits, private reset
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst3_n;
  logic [3:0] rx;
  logic [3:0] ready;
  logic [3:0] valid, parity_err, frame_err, overrun, busy;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;

  int checks = 0;
  int errors = 0;

  int vrise [4];
  logic [3:0] prev_valid;
  int ovr_cnt;
  int vlow2;

  always #5 clk = ~clk;

  uart_rx_param u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data_out(d0), .valid(valid[0]),
    .ready(ready[0]), .parity_err(parity_err[0]), .frame_err(frame_err[0]),
    .overrun(overrun[0]), .busy(busy[0])
  );

  uart_rx_param #(.CLKS_PER_BIT(16), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data_out(d1), .valid(valid[1]),
    .ready(ready[1]), .parity_err(parity_err[1]), .frame_err(frame_err[1]),
    .overrun(overrun[1]), .busy(busy[1])
  );

  uart_rx_param #(.CLKS_PER_BIT(16)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx[2]), .data_out(d2), .valid(valid[2]),
    .ready(ready[2]), .parity_err(parity_err[2]), .frame_err(frame_err[2]),
    .overrun(overrun[2]), .busy(busy[2])
  );

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst3_n), .rx(rx[3]), .data_out(d3), .valid(valid[3]),
    .ready(ready[3]), .parity_err(parity_err[3]), .frame_err(frame_err[3]),
    .overrun(overrun[3]), .busy(busy[3])
  );

  // Event monitors: rising edges of valid, overrun pulses and low-valid
  // samples on u2.
  initial begin
    for (int k = 0; k < 4; k++) vrise[k] = 0;
    prev_valid = '0;
    ovr_cnt    = 0;
    vlow2      = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (valid[k] && !prev_valid[k]) vrise[k] <= vrise[k] + 1;
    prev_valid <= valid;
    if (overrun[2]) ovr_cnt <= ovr_cnt + 1;
    if (!valid[2])  vlow2   <= vlow2 + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] get_data(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {1'b0, d2};
      default: return {2'b00, d3};
    endcase
  endfunction

  task automatic drive_bit(input int k, input int cpb, input logic v);
    rx[k] = v;
    repeat (cpb) @(negedge clk);
  endtask

  // par < 0 means no parity bit; otherwise par[0] is the parity bit sent.
  task automatic send_frame(input int k, input int cpb, input int nbits,
                            input logic [8:0] data, input int par,
                            input logic stop_v, input int nstop);
    drive_bit(k, cpb, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(k, cpb, data[i]);
    if (par >= 0) drive_bit(k, cpb, par[0]);
    for (int i = 0; i < nstop; i++) drive_bit(k, cpb, stop_v);
    rx[k] = 1'b1;
  endtask

  task automatic wait_valid(input int k, input int budget);
    for (int i = 0; i < budget && !valid[k]; i++) @(negedge clk);
  endtask

  task automatic accept(input int k);
    ready[k] = 1'b1;
    @(negedge clk);
    ready[k] = 1'b0;
  endtask

  int base_rise, base_ovr, base_vlow, n;

  initial begin
    rx     = '1;
    ready  = '0;
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_valid",  valid[0], 1'b0);
    check("rst_busy",   busy[0],  1'b0);
    check("rst_data",   d0,       8'h00);
    check("rst_errs",   {parity_err[0], frame_err[0], overrun[0]}, 3'b000);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    repeat (3) @(negedge clk);

    // Default parameters: 0x3F 8N1 at 868 clocks per bit
    send_frame(0, 868, 8, 9'h03F, -1, 1'b1, 1);
    wait_valid(0, 2000);
    check("def_valid",  valid[0],      1'b1);
    check("def_data",   d0,            8'h3F);
    check("def_perr",   parity_err[0], 1'b0);
    check("def_ferr",   frame_err[0],  1'b0);
    repeat (100) @(negedge clk);
    check("def_hold_valid", valid[0], 1'b1);
    check("def_hold_data",  d0,       8'h3F);
    accept(0);
    check("def_accepted", valid[0], 1'b0);

    // 200-clock glitch on the idle line
    base_rise = vrise[0];
    drive_bit(0, 200, 1'b0);
    rx[0] = 1'b1;
    n = 0;
    while (busy[0] && n < 434) begin
      @(negedge clk);
      n++;
    end
    check("glitch_idle", busy[0], 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_no_valid", vrise[0] - base_rise, 0);

    // Even parity: 0xA5 has four ones, so the correct parity bit is 0
    send_frame(1, 16, 8, 9'h0A5, 1, 1'b1, 1);
    wait_valid(1, 40);
    check("par_bad_valid", valid[1],      1'b1);
    check("par_bad_data",  d1,            8'hA5);
    check("par_bad_perr",  parity_err[1], 1'b1);
    accept(1);
    send_frame(1, 16, 8, 9'h0A5, 0, 1'b1, 1);
    wait_valid(1, 40);
    check("par_ok_data", d1,            8'hA5);
    check("par_ok_perr", parity_err[1], 1'b0);
    check("par_ok_ferr", frame_err[1],  1'b0);
    accept(1);

    // Low stop bit, then the line stays low for 20 bit times in total
    send_frame(2, 16, 8, 9'h05A, -1, 1'b0, 1);
    rx[2] = 1'b0;
    wait_valid(2, 40);
    check("brk_valid", valid[2],     1'b1);
    check("brk_data",  d2,           8'h5A);
    check("brk_ferr",  frame_err[2], 1'b1);
    accept(2);
    repeat (2) @(negedge clk);
    base_rise = vrise[2];
    n = 0;
    for (int i = 0; i < 19 * 16; i++) begin
      if (!busy[2]) n++;
      @(negedge clk);
    end
    check("brk_busy_held", n, 0);
    rx[2] = 1'b1;
    n = 0;
    while (busy[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("brk_released", busy[2], 1'b0);
    repeat (40) @(negedge clk);
    check("brk_no_second_valid", vrise[2] - base_rise, 0);

    // Back-to-back 0x11, 0x22 with ready low: the second word is dropped
    base_ovr = ovr_cnt;
    send_frame(2, 16, 8, 9'h011, -1, 1'b1, 1);
    send_frame(2, 16, 8, 9'h022, -1, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("ovr_pulses", ovr_cnt - base_ovr, 1);
    check("ovr_data",   d2,       8'h11);
    check("ovr_valid",  valid[2], 1'b1);
    accept(2);
    check("ovr_accepted", valid[2], 1'b0);

    // The same with ready high on the completion cycle of 0x22. The word
    // loads on the 157th rising edge after the start bit is driven, so
    // ready is raised at the 156th falling edge.
    send_frame(2, 16, 8, 9'h011, -1, 1'b1, 1);
    base_ovr  = ovr_cnt;
    base_vlow = vlow2;
    fork
      send_frame(2, 16, 8, 9'h022, -1, 1'b1, 1);
      begin
        repeat (156) @(negedge clk);
        accept(2);
      end
    join
    repeat (4) @(negedge clk);
    check("hs_data",      d2,                 8'h22);
    check("hs_valid",     valid[2],           1'b1);
    check("hs_no_ovr",    ovr_cnt - base_ovr, 0);
    check("hs_valid_gap", vlow2 - base_vlow,  0);
    accept(2);

    // 7 data bits, 2 stop bits: reset during data bit 3 aborts the frame.
    // Bits 3..6 of 0x7A are ones, so the line stays high after release.
    base_rise = vrise[3];
    fork
      send_frame(3, 16, 7, 9'h07A, -1, 1'b1, 2);
      begin
        repeat (70) @(negedge clk);
        rst3_n = 1'b0;
        @(negedge clk);
        check("abort_rst_busy", busy[3], 1'b0);
        repeat (2) @(negedge clk);
        rst3_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check("abort_no_valid", vrise[3] - base_rise, 0);
    check("abort_idle",     busy[3], 1'b0);
    send_frame(3, 16, 7, 9'h055, -1, 1'b1, 2);
    wait_valid(3, 40);
    check("after_abort_valid", valid[3],     1'b1);
    check("after_abort_data",  d3,           7'h55);
    check("after_abort_ferr",  frame_err[3], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
